// File: rtl/ram_ctrl_if.sv
// Request/response and RAM pin bundle for ram_ctrl.
// slave = controller side, master = requester plus RAM side.
interface ram_ctrl_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              wr_done;
  logic              busy;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, wr_done, busy,
           ram_wr, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, wr_done, busy,
           ram_wr, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_ctrl.sv
// Synchronous controller for a latch-based RAM: setup/pulse/hold writes, two-cycle reads.
// Define RAM_CTRL_INIT_EN to zero-fill the whole RAM after every reset.
module ram_ctrl #(
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        reset,
  ram_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] W_SETUP = 3'd1;
  localparam logic [2:0] W_PULSE = 3'd2;
  localparam logic [2:0] W_HOLD  = 3'd3;
  localparam logic [2:0] R_ADDR  = 3'd4;
  localparam logic [2:0] R_CAPT  = 3'd5;
`ifdef RAM_CTRL_INIT_EN
  localparam logic [2:0] INIT    = 3'd6;
  localparam logic [2:0] RST_STATE = INIT;
  localparam logic       RST_READY = 1'b0;
  localparam logic       RST_BUSY  = 1'b1;
`else
  localparam logic [2:0] RST_STATE = IDLE;
  localparam logic       RST_READY = 1'b1;
  localparam logic       RST_BUSY  = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              wr_done_q, wr_done_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
`ifdef RAM_CTRL_INIT_EN
  logic              init_q, init_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_done_q   <= 1'b0;
      req_ready_q <= RST_READY;
      busy_q      <= RST_BUSY;
`ifdef RAM_CTRL_INIT_EN
      init_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_done_q   <= wr_done_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
`ifdef RAM_CTRL_INIT_EN
      init_q      <= init_d;
`endif
    end
  end

  // Next-state and next-output logic; ram_wr_d defaults low so the strobe only rises from setup
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    wr_done_d   = 1'b0;
`ifdef RAM_CTRL_INIT_EN
    init_d      = init_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          ram_addr_d = bus.req_addr;
          if (bus.req_we) begin
            ram_wdata_d = bus.req_wdata;
            state_d     = W_SETUP;
          end else begin
            state_d = R_ADDR;
          end
        end
      end
      W_SETUP: begin
        ram_wr_d = 1'b1;
        cnt_d    = '0;
        state_d  = W_PULSE;
      end
      W_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = W_HOLD;
        end else begin
          ram_wr_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      W_HOLD: begin
`ifdef RAM_CTRL_INIT_EN
        if (init_q) begin
          if (ram_addr_q == ADDR_LAST) begin
            init_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_W'(1);
            state_d    = INIT;
          end
        end else begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
`else
        wr_done_d = 1'b1;
        state_d   = IDLE;
`endif
      end
      R_ADDR: begin
        state_d = R_CAPT;
      end
      R_CAPT: begin
        rsp_rdata_d = bus.ram_rdata;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
`ifdef RAM_CTRL_INIT_EN
      // Zero-fill step: acts as the setup cycle; ram_wdata stays at its reset value of 0
      INIT: begin
        ram_wr_d = 1'b1;
        cnt_d    = '0;
        state_d  = W_PULSE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl with a behavioural 4x4 RAM model.
// Build with RAM_CTRL_INIT_EN to exercise the zero-fill sequence (WR_PULSE=2).
module tb_ram_ctrl;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 4;
`ifdef RAM_CTRL_INIT_EN
  localparam int unsigned WR_PULSE = 2;
  localparam logic RST_READY = 1'b0;
  localparam logic RST_BUSY  = 1'b1;
`else
  localparam int unsigned WR_PULSE = 1;
  localparam logic RST_READY = 1'b1;
  localparam logic RST_BUSY  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_PULSE(WR_PULSE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: pre-filled with F so zero-fill and writes are visible
  logic [DATA_W-1:0] mem [4] = '{default: 4'hF};
  always @(negedge clk) if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_addr];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address/data must not move across any edge where the strobe is high on either side
  logic              rst_seen = 1'b1;
  logic              inv_wr   = 1'b0;
  logic [ADDR_W-1:0] inv_addr = '0;
  logic [DATA_W-1:0] inv_data = '0;
  always @(posedge clk) rst_seen <= reset;
  always @(negedge clk) begin
    if (!rst_seen && (inv_wr || bus.ram_wr)) begin
      chk("stable_addr", 32'(bus.ram_addr), 32'(inv_addr));
      chk("stable_data", 32'(bus.ram_wdata), 32'(inv_data));
    end
    inv_wr   <= bus.ram_wr;
    inv_addr <= bus.ram_addr;
    inv_data <= bus.ram_wdata;
  end

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d;
    chk("wr_accept_ready", 32'(bus.req_ready), 1);
    tick;
    bus.req_valid = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~d;
    chk("wr_setup_wr", 32'(bus.ram_wr), 0);
    chk("wr_setup_addr", 32'(bus.ram_addr), 32'(a));
    chk("wr_setup_data", 32'(bus.ram_wdata), 32'(d));
    chk("wr_setup_busy", 32'(bus.busy), 1);
    for (int i = 0; i < int'(WR_PULSE); i++) begin
      tick;
      chk("wr_pulse_wr", 32'(bus.ram_wr), 1);
    end
    tick;
    chk("wr_hold_wr", 32'(bus.ram_wr), 0);
    chk("wr_hold_addr", 32'(bus.ram_addr), 32'(a));
    chk("wr_hold_done", 32'(bus.wr_done), 0);
    chk("wr_hold_ready", 32'(bus.req_ready), 0);
    tick;
    chk("wr_done", 32'(bus.wr_done), 1);
    chk("wr_done_ready", 32'(bus.req_ready), 1);
    chk("wr_done_rspv", 32'(bus.rsp_valid), 0);
    chk("wr_mem", 32'(mem[a]), 32'(d));
  endtask

  task automatic do_read(input logic [1:0] a, input logic [3:0] exp);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
    chk("rd_accept_ready", 32'(bus.req_ready), 1);
    tick;
    bus.req_valid = 1'b0; bus.req_addr = ~a;
    chk("rd_e1_rspv", 32'(bus.rsp_valid), 0);
    tick;
    chk("rd_e2_rspv", 32'(bus.rsp_valid), 0);
    tick;
    chk("rd_rspv", 32'(bus.rsp_valid), 1);
    chk("rd_rdata", 32'(bus.rsp_rdata), 32'(exp));
    chk("rd_ready", 32'(bus.req_ready), 1);
    chk("rd_wr_done", 32'(bus.wr_done), 0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    reset = 1'b1;
`ifdef RAM_CTRL_INIT_EN
    // Zero-fill: ready low for 4*(WR_PULSE+2) cycles, no wr_done
    tick;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("init_ready", 32'(bus.req_ready), 0);
      chk("init_wr_done", 32'(bus.wr_done), 0);
      tick;
    end
    chk("init_end_ready", 32'(bus.req_ready), 1);
    chk("init_end_busy", 32'(bus.busy), 0);
    for (int a = 0; a < 4; a++) do_read(2'(a), 4'h0);
`else
    tick; tick;
    reset = 1'b0;
    tick; tick; tick;
    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_ram_wr", 32'(bus.ram_wr), 0);
    chk("idle_rspv", 32'(bus.rsp_valid), 0);
    chk("idle_wr_done", 32'(bus.wr_done), 0);
    chk("idle_ram_addr", 32'(bus.ram_addr), 0);
    chk("idle_ram_wdata", 32'(bus.ram_wdata), 0);
    chk("idle_rdata", 32'(bus.rsp_rdata), 0);
`endif

    // Single write, then back-to-back writes and reads
    do_write(2'd2, 4'hA);
    do_write(2'd0, 4'h5);
    do_write(2'd1, 4'h3);
    do_write(2'd3, 4'hC);
    do_read(2'd0, 4'h5);
    do_read(2'd1, 4'h3);
    do_read(2'd3, 4'hC);
    tick;
    chk("rdata_hold", 32'(bus.rsp_rdata), 'hC);
    chk("rspv_pulse", 32'(bus.rsp_valid), 0);
    do_read(2'd2, 4'hA);

    // Request held valid with wandering fields while busy
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 2'd1; bus.req_wdata = 4'h6;
    tick;
    bus.req_we = 1'b0;
    for (int i = 0; i < int'(WR_PULSE) + 2; i++) begin
      bus.req_addr = 2'(i + 2); bus.req_wdata = 4'(i + 9);
      chk("busy_ready", 32'(bus.req_ready), 0);
      chk("busy_addr", 32'(bus.ram_addr), 1);
      chk("busy_wdata", 32'(bus.ram_wdata), 'h6);
      tick;
    end
    bus.req_addr = 2'd1;
    chk("busy_wr_done", 32'(bus.wr_done), 1);
    tick;
    bus.req_valid = 1'b0;
    tick; tick;
    chk("b2b_rspv", 32'(bus.rsp_valid), 1);
    chk("b2b_rdata", 32'(bus.rsp_rdata), 'h6);
    chk("untouched_mem3", 32'(mem[3]), 'hC);

    // Reset in the middle of a write pulse
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 2'd1; bus.req_wdata = 4'hF;
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("abort_pulse_wr", 32'(bus.ram_wr), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_ram_wr", 32'(bus.ram_wr), 0);
    chk("abort_ready", 32'(bus.req_ready), 32'(RST_READY));
    chk("abort_busy", 32'(bus.busy), 32'(RST_BUSY));
    chk("abort_addr", 32'(bus.ram_addr), 0);
    chk("abort_wdata", 32'(bus.ram_wdata), 0);
    chk("abort_rdata", 32'(bus.rsp_rdata), 0);
    chk("abort_wr_done", 32'(bus.wr_done), 0);
    tick;
    chk("abort_no_done", 32'(bus.wr_done), 0);
    for (int i = 0; i < 40 && !bus.req_ready; i++) tick;
    chk("abort_ready_again", 32'(bus.req_ready), 1);
    do_write(2'd1, 4'h7);
    do_read(2'd1, 4'h7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
Synchronous front-end controller for the 4x4 latch-based RAM (2-bit address, 4-bit data, level-sensitive write strobe, no clock).
Accepts read/write requests over a valid/ready handshake and sequences the RAM pins so that address and data are stable whenever the strobe is high: setup, then pulse, then hold.
Registers read data and returns it with a one-cycle response pulse.
Sits directly upstream of the RAM; it owns every RAM input and consumes the RAM output.

Parameters:
ADDR_W, 2, RAM address width (number of words = 2**ADDR_W).
DATA_W, 4, RAM word width.
WR_PULSE, 1, number of cycles ram_wr is held high per write; legal values >= 1, 0 is illegal.

Ports:
clk  input  1  system clock, rising-edge active.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  request address.
req_wdata  input  DATA_W  write data.
rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid.
rsp_rdata  output  DATA_W  read data.
wr_done  output  1  one-cycle pulse when a write sequence completes.
busy  output  1  high whenever the FSM is not in IDLE.
ram_wr  output  1  RAM write strobe (level).
ram_addr  output  ADDR_W  RAM address.
ram_wdata  output  DATA_W  RAM input data.
ram_rdata  input  DATA_W  RAM output data.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. Every output is registered.
- Reset values:
  - State = IDLE (or INIT when the optional feature is enabled).
  - ram_wr=0, ram_addr=0, ram_wdata=0.
  - rsp_valid=0, rsp_rdata=0, wr_done=0.
  - busy=0, req_ready=1 (0 in INIT).
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - Request fields are sampled only at acceptance; later changes to them are ignored.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_CAPT (plus INIT with the optional feature).
- IDLE, on accept:
  - ram_addr <= req_addr.
  - Write: ram_wdata <= req_wdata; go to W_SETUP.
  - Read: go to R_ADDR.
- Write sequence:
  - W_SETUP: ram_wr=0 for 1 cycle, then ram_wr <= 1 and go to W_PULSE.
  - W_PULSE: stay WR_PULSE cycles with ram_wr=1, then ram_wr <= 0 and go to W_HOLD.
  - W_HOLD: 1 cycle with ram_wr=0 and address/data unchanged, then wr_done <= 1 and go to IDLE.
  - Accept to ready-again = WR_PULSE+3 edges.
- Read sequence:
  - R_ADDR: ram_wr=0, 1-cycle settle, then go to R_CAPT.
  - R_CAPT: rsp_rdata <= ram_rdata, rsp_valid <= 1, go to IDLE.
  - rsp_valid is high in the cycle after the third edge following accept; req_ready is high in that same cycle.
- Invariants:
  - ram_addr and ram_wdata change only on edges where ram_wr is 0 both before and after the edge.
  - ram_wr is never high outside W_PULSE.
  - Only one request is outstanding at a time; no queueing.
- rsp_valid and wr_done are single-cycle pulses and are never high together.
- rsp_rdata holds its last value until the next read capture.
- Back-to-back requests: a request held valid in the cycle rsp_valid or wr_done is high is accepted on that edge.
- Reset mid-operation: all outputs take their reset values on the reset edge and ram_wr drops to 0. The content of a word interrupted during W_PULSE is undefined. No response is produced for the aborted request.

Optional Feature:
Macro: RAM_CTRL_INIT_EN.
- Defined:
  - After reset the FSM enters INIT and writes 0 to every address, 0 to 2**ADDR_W-1 ascending.
  - Each write uses the same setup/pulse/hold sequence as a normal write.
  - req_ready=0 and busy=1 throughout INIT; wr_done is not pulsed.
  - The FSM enters IDLE after the last hold cycle.
  - Total INIT length = 2**ADDR_W * (WR_PULSE+2) cycles.
- Not defined: INIT state is absent; the FSM enters IDLE directly from reset and RAM contents are undefined until written.

Test Plan:
- Reset, then idle 3 cycles -> req_ready=1, busy=0, ram_wr=0, rsp_valid=0, all data outputs 0.
- Write addr 2 data 4'hA with WR_PULSE=1 -> ram_addr=2 and ram_wdata=A one cycle before ram_wr rises; ram_wr high exactly 1 cycle; addr/data unchanged 1 cycle after it falls; wr_done pulses; req_ready returns 4 edges after accept.
- Write 4'h5 to addr 0, 4'h3 to addr 1, 4'hC to addr 3, then read addrs 0, 1, 3 back-to-back -> three rsp_valid pulses carrying 5, 3, C, each 3 edges after its accept.
- Hold req_valid high with changing req_addr while busy -> no accept until req_ready=1; the earlier transaction is unaffected; a checker asserts ram_addr/ram_wdata never change while ram_wr=1.
- Assert reset during W_PULSE of a write of 4'hF to addr 1 -> ram_wr=0 and state IDLE on the reset edge; no wr_done; a subsequent write and read of addr 1 return the new value.
- With RAM_CTRL_INIT_EN and WR_PULSE=2 -> req_ready=0 for 16 cycles after reset; reads of addrs 0-3 then return 0.
